// File: rtl/mycpu_pkg.sv
// Shared constants and the fetch-queue entry type for the mycpu front end.
package mycpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam int          INST_BYTES       = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;

endpackage

// File: rtl/mycpu_fetch_unit_if.sv
// Fetch-unit bus bundle: inst SRAM port, redirect input and the decode handshake.
interface mycpu_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_sram_we;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_wdata;
  logic [DATA_W-1:0] inst_sram_rdata;
  logic              fs_valid;
  logic [ADDR_W-1:0] fs_pc;
  logic [DATA_W-1:0] fs_inst;
  logic              fs_adef;
  logic              ds_ready;

  // master: the fetch unit itself
  modport master (
    input  redirect_valid, redirect_pc, inst_sram_rdata, ds_ready,
    output inst_sram_we, inst_sram_addr, inst_sram_wdata,
           fs_valid, fs_pc, fs_inst, fs_adef
  );

  // slave: back end, SRAM and decode as seen from the other side
  modport slave (
    output redirect_valid, redirect_pc, inst_sram_rdata, ds_ready,
    input  inst_sram_we, inst_sram_addr, inst_sram_wdata,
           fs_valid, fs_pc, fs_inst, fs_adef
  );
endinterface

// File: rtl/mycpu_fetch_fifo.sv
// Prefetch FIFO: extra-MSB pointers, combinational head, flush has priority over push/pop.
module mycpu_fetch_fifo
  import mycpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic          empty,
  output logic          full,
  output logic [PW-1:0] count
);

  logic [PW-1:0] wr_ptr, rd_ptr;
  entry_t        mem [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/mycpu_fetch_unit.sv
// Instruction fetch front end: one in-flight SRAM read, prefetch FIFO, redirect and ADEF handling.
module mycpu_fetch_unit
  import mycpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input logic                clk,
  input logic                resetn,
  mycpu_fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              adef;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc, pc_q;
  logic              rsp_pending, adef_pending, halted;
  logic              issue, aligned, push, pop, empty, full;
  logic [PW-1:0]     count;
  logic [PW:0]       occ;
  entry_t            push_data, head;

  // occupancy counts the read in flight so a returning word always has a slot
  assign occ     = {1'b0, count} + (PW+1)'(rsp_pending);
  assign issue   = !bus.redirect_valid && !halted && (occ < (PW+1)'(DEPTH));
  assign aligned = (fetch_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc     <= RESET_PC;
      pc_q         <= '0;
      rsp_pending  <= 1'b0;
      adef_pending <= 1'b0;
      halted       <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc     <= bus.redirect_pc;
      rsp_pending  <= 1'b0;
      adef_pending <= 1'b0;
      halted       <= 1'b0;
    end else begin
      rsp_pending  <= issue && aligned;
      adef_pending <= issue && !aligned;
      if (issue) begin
        pc_q <= fetch_pc;
        // a misaligned PC is reported once, then fetch parks until redirected
        if (aligned) fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);
        else         halted   <= 1'b1;
      end
    end
  end

  always_comb begin
    push_data      = '0;
    push_data.pc   = pc_q;
    push_data.inst = adef_pending ? '0 : bus.inst_sram_rdata;
    push_data.adef = adef_pending;
  end

  assign push = rsp_pending || adef_pending;
  assign pop  = !empty && bus.ds_ready && !bus.redirect_valid;

  mycpu_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  a_issue_guard: assert property (@(posedge clk) disable iff (!resetn)
    !(push && full && !pop && !bus.redirect_valid));

  assign bus.inst_sram_we    = 1'b0;
  assign bus.inst_sram_addr  = fetch_pc;
  assign bus.inst_sram_wdata = '0;
  assign bus.fs_valid        = !empty;
  assign bus.fs_pc           = head.pc;
  assign bus.fs_inst         = head.inst;
  assign bus.fs_adef         = head.adef;

endmodule

// File: tb/tb_mycpu_fetch_unit.sv
// Directed bench for mycpu_fetch_unit: streaming, back-pressure, redirects, ADEF, async reset.
module tb_mycpu_fetch_unit;
  import mycpu_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mycpu_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mycpu_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h1c000000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // single-cycle-latency SRAM, word(addr) = ~addr
  always @(posedge clk) bus.inst_sram_rdata <= bus.inst_sram_addr ^ 32'hffffffff;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(bus.fs_valid), 32'd1);
    chk({tag, "_pc"},    bus.fs_pc, pc);
    chk({tag, "_inst"},  bus.fs_inst, pc ^ 32'hffffffff);
    chk({tag, "_adef"},  32'(bus.fs_adef), 32'd0);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(bus.fs_valid), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  // leaves the bench in cycle 0 after release
  task automatic do_reset(input logic rdy);
    resetn             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.ds_ready       = rdy;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn             = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.ds_ready       = 1'b1;
    tick();
    tick();

    // reset state
    chk("rst_valid", 32'(bus.fs_valid), 32'd0);
    chk("rst_pc",    bus.fs_pc, 32'd0);
    chk("rst_inst",  bus.fs_inst, 32'd0);
    chk("rst_adef",  32'(bus.fs_adef), 32'd0);
    chk("rst_addr",  bus.inst_sram_addr, 32'h1c000000);
    chk("rst_we",    32'(bus.inst_sram_we), 32'd0);

    // release: first valid in cycle 2, then one per cycle
    resetn = 1'b1;
    chk_empty("c0");
    tick();
    chk_empty("c1");
    tick();
    for (int k = 0; k < 6; k++) begin
      chk_head("stream", 32'h1c000000 + 32'(4 * k));
      tick();
    end

    // back-pressure: exactly four entries held, then in-order drain with no gaps
    do_reset(1'b0);
    repeat (10) tick();
    chk("stall_addr", bus.inst_sram_addr, 32'h1c000010);
    chk_head("stall_head", 32'h1c000000);
    bus.ds_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head("drain", 32'h1c000000 + 32'(4 * k));
      tick();
    end

    // redirect while two entries are buffered and a read is in flight
    do_reset(1'b0);
    repeat (3) tick();
    chk_head("pre_redir", 32'h1c000000);
    redirect(32'h1c001000);
    tick();
    bus.redirect_valid = 1'b0;
    chk_empty("redir_r1");
    tick();
    chk_empty("redir_r2");
    tick();
    chk_head("redir_r3", 32'h1c001000);
    bus.ds_ready = 1'b1;
    tick();
    chk_head("redir_r4", 32'h1c001004);
    tick();
    chk_head("redir_r5", 32'h1c001008);

    // misaligned target: one ADEF marker, then fetch parks
    redirect(32'h1c000102);
    tick();
    bus.redirect_valid = 1'b0;
    chk_empty("adef_r1");
    tick();
    chk_empty("adef_r2");
    tick();
    chk("adef_valid", 32'(bus.fs_valid), 32'd1);
    chk("adef_pc",    bus.fs_pc, 32'h1c000102);
    chk("adef_inst",  bus.fs_inst, 32'd0);
    chk("adef_flag",  32'(bus.fs_adef), 32'd1);
    tick();
    chk_empty("adef_r4");
    chk("adef_addr_r4", bus.inst_sram_addr, 32'h1c000102);
    tick();
    tick();
    chk_empty("adef_r6");
    chk("adef_addr_r6", bus.inst_sram_addr, 32'h1c000102);
    redirect(32'h1c000200);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    chk_head("resume_s3", 32'h1c000200);
    tick();
    chk_head("resume_s4", 32'h1c000204);

    // redirect concurrent with a pop, then back-to-back redirects A, B
    chk("b2b_pre_valid", 32'(bus.fs_valid), 32'd1);
    redirect(32'h1c002000);
    tick();
    redirect(32'h1c003000);
    chk_empty("b2b_r1");
    tick();
    bus.redirect_valid = 1'b0;
    chk_empty("b2b_r2");
    tick();
    chk_empty("b2b_r3");
    tick();
    chk_head("b2b_r4", 32'h1c003000);
    tick();
    chk_head("b2b_r5", 32'h1c003004);

    // asynchronous reset with three entries buffered
    do_reset(1'b0);
    repeat (4) tick();
    chk_head("pre_arst", 32'h1c000000);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.fs_valid), 32'd0);
    chk("arst_addr",  bus.inst_sram_addr, 32'h1c000000);
    tick();
    tick();
    resetn       = 1'b1;
    bus.ds_ready = 1'b1;
    chk_empty("arst_c0");
    tick();
    tick();
    chk_head("arst_c2", 32'h1c000000);
    tick();
    chk_head("arst_c3", 32'h1c000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
